// File: rtl/pdu_pkg.sv
// Shared types and defaults for the debug-unit run controller and its button front end.
package pdu_pkg;

   typedef enum logic [1:0] {
      StPause  = 2'd0,
      StStep   = 2'd1,
      StRun    = 2'd2,
      StInWait = 2'd3
   } run_state_e;

   localparam int unsigned DbWDefault      = 16;
   localparam logic [15:0] DbCyclesDefault = 16'd50000;

endpackage

// File: rtl/btn_pulse.sv
// Front-panel button conditioner: 2-FF synchronizer, stable-level debounce, and a
// registered one-cycle pulse on each accepted press.
module btn_pulse
   import pdu_pkg::*;
#(
   parameter int unsigned     DB_W      = DbWDefault,
   parameter logic [DB_W-1:0] DB_CYCLES = DB_W'(DbCyclesDefault)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic pulse_o
);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d, stable_prev_q;
   logic            pulse_q;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // The accepted level flips only after DB_CYCLES consecutive samples disagree with it.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == DB_CYCLES - 1'b1) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         cnt_q         <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         pulse_q       <= 1'b0;
      end else begin
         sync1_q       <= btn_i;
         sync2_q       <= sync1_q;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         pulse_q       <= stable_q & ~stable_prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/pdu_run_ctrl.sv
// Debug-unit execution sequencer: drives the CPU clock-enable for pause, single-step,
// continuous run, PC breakpoints and operator-confirmed IO input reads.
module pdu_run_ctrl
   import pdu_pkg::*;
#(
   parameter int unsigned     DB_W      = DbWDefault,
   parameter logic [DB_W-1:0] DB_CYCLES = DB_W'(DbCyclesDefault)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic        cont,
   input  logic        ent,
   input  logic        brk_en,
   input  logic [31:0] brk_addr,
   input  logic [31:0] pc,
   input  logic        io_rd,
   output logic        cpu_en,
   output logic        pause,
   output logic        in_wait,
   output logic        brk_hit,
   output logic [31:0] cyc_cnt
);

   logic step_p, cont_p, ent_p;

   btn_pulse #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_step_pulse (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (step),
      .pulse_o(step_p)
   );

   btn_pulse #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_cont_pulse (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (cont),
      .pulse_o(cont_p)
   );

   btn_pulse #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_ent_pulse (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (ent),
      .pulse_o(ent_p)
   );

   run_state_e  state_q;
   logic        ret_run_q, in_vld_q, skip_brk_q, brk_hit_q;
   logic [31:0] cyc_q, cyc_d;
   logic        brk_match, io_stall;

   always_comb begin
      brk_match = brk_en & (pc == brk_addr) & ~skip_brk_q;
      io_stall  = io_rd & ~in_vld_q;
      cpu_en    = 1'b0;
      case (state_q)
         StRun:   cpu_en = ~brk_match & ~io_stall;
         StStep:  cpu_en = ~io_stall;
         default: cpu_en = 1'b0;
      endcase
      cyc_d = cyc_q + 32'(cpu_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StPause;
         ret_run_q  <= 1'b0;
         in_vld_q   <= 1'b0;
         skip_brk_q <= 1'b0;
         brk_hit_q  <= 1'b0;
         cyc_q      <= '0;
      end else begin
         cyc_q <= cyc_d;
         // Any committed instruction consumes the confirmed input and the breakpoint skip.
         if (cpu_en) begin
            skip_brk_q <= 1'b0;
            if (io_rd) begin
               in_vld_q <= 1'b0;
            end
         end
         case (state_q)
            StPause: begin
               if (cont_p) begin
                  state_q    <= StRun;
                  skip_brk_q <= 1'b1;
                  brk_hit_q  <= 1'b0;
               end else if (step_p) begin
                  state_q   <= StStep;
                  brk_hit_q <= 1'b0;
               end
            end
            StStep: begin
               if (io_stall) begin
                  state_q   <= StInWait;
                  ret_run_q <= 1'b0;
               end else begin
                  state_q <= StPause;
               end
            end
            StRun: begin
               if (cont_p) begin
                  state_q <= StPause;
               end else if (brk_match) begin
                  state_q   <= StPause;
                  brk_hit_q <= 1'b1;
               end else if (io_stall) begin
                  state_q   <= StInWait;
                  ret_run_q <= 1'b1;
               end
            end
            StInWait: begin
               if (ent_p) begin
                  in_vld_q <= 1'b1;
                  state_q  <= ret_run_q ? StRun : StStep;
               end else if (cont_p) begin
                  state_q <= StPause;
               end
            end
            default: state_q <= StPause;
         endcase
      end
   end

   assign pause   = (state_q != StRun);
   assign in_wait = (state_q == StInWait);
   assign brk_hit = brk_hit_q;
   assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// Self-checking bench for pdu_run_ctrl: per-cycle reference model, a combinational
// vector table, directed scenarios and randomized button traffic.
module tb_pdu_run_ctrl;

   localparam int unsigned DB  = 4;
   localparam int          LAT = DB + 3;

   localparam int ModeHalt = 0;
   localparam int ModeStep = 1;
   localparam int ModeRun  = 2;
   localparam int ModeWait = 3;

   logic        clk     = 1'b0;
   logic        clk_run = 1'b1;
   logic        rst, step, cont, ent, brk_en, io_rd;
   logic [31:0] brk_addr, pc;
   logic        cpu_en, pause, in_wait, brk_hit;
   logic [31:0] cyc_cnt;

   pdu_run_ctrl #(.DB_CYCLES(16'(DB))) dut (
      .clk     (clk),
      .rst     (rst),
      .step    (step),
      .cont    (cont),
      .ent     (ent),
      .brk_en  (brk_en),
      .brk_addr(brk_addr),
      .pc      (pc),
      .io_rd   (io_rd),
      .cpu_en  (cpu_en),
      .pause   (pause),
      .in_wait (in_wait),
      .brk_hit (brk_hit),
      .cyc_cnt (cyc_cnt)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   typedef struct {
      logic        brk_en;
      logic [31:0] brk_addr;
      logic [31:0] pc;
      logic        io_rd;
      logic        exp_en;
   } vec_t;

   vec_t        vecs[8];
   int          n_tests, n_fail, ncyc;
   int          due_s, due_c, due_e, hold_s, hold_c, hold_e;
   logic        io_on, en_seen;
   logic [31:0] io_pc;
   bit          chk_on, table_req;

   // Reference model state
   int          m_mode;
   bit          m_ret, m_in_vld, m_skip, m_brk_hit;
   bit          m_en, m_stall, m_bp, m_sp, m_cp, m_ep;
   logic [31:0] m_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic eval_check();
      m_sp    = (due_s == ncyc);
      m_cp    = (due_c == ncyc);
      m_ep    = (due_e == ncyc);
      m_stall = io_rd && !m_in_vld;
      m_bp    = brk_en && (pc == brk_addr) && !m_skip;
      if (m_mode == ModeRun) m_en = !m_bp && !m_stall;
      else if (m_mode == ModeStep) m_en = !m_stall;
      else m_en = 1'b0;
      en_seen = cpu_en;
      if (chk_on) begin
         chkb("cyc cpu_en", cpu_en, m_en);
         chkb("cyc pause", pause, m_mode != ModeRun);
         chkb("cyc in_wait", in_wait, m_mode == ModeWait);
         chkb("cyc brk_hit", brk_hit, m_brk_hit);
         chk("cyc cyc_cnt", cyc_cnt, m_cyc);
      end
   endtask

   task automatic advance();
      if (rst) begin
         m_mode = ModeHalt;
         m_ret = 0; m_in_vld = 0; m_skip = 0; m_brk_hit = 0; m_cyc = '0;
         chk_on = 1'b1;
         return;
      end
      if (m_en) begin
         m_cyc  = m_cyc + 32'd1;
         m_skip = 1'b0;
         if (io_rd) m_in_vld = 1'b0;
      end
      if (m_mode == ModeHalt) begin
         if (m_cp) begin
            m_mode = ModeRun; m_skip = 1'b1; m_brk_hit = 1'b0;
         end else if (m_sp) begin
            m_mode = ModeStep; m_brk_hit = 1'b0;
         end
      end else if (m_mode == ModeStep) begin
         if (m_stall) begin
            m_mode = ModeWait; m_ret = 1'b0;
         end else begin
            m_mode = ModeHalt;
         end
      end else if (m_mode == ModeRun) begin
         if (m_cp) m_mode = ModeHalt;
         else if (m_bp) begin
            m_mode = ModeHalt; m_brk_hit = 1'b1;
         end else if (m_stall) begin
            m_mode = ModeWait; m_ret = 1'b1;
         end
      end else begin
         if (m_ep) begin
            m_in_vld = 1'b1;
            m_mode   = m_ret ? ModeRun : ModeStep;
         end else if (m_cp) m_mode = ModeHalt;
      end
   endtask

   // Runs with the clock parked low, so only the combinational cpu_en path is exercised.
   task automatic run_table();
      logic        s_brk_en, s_io_rd;
      logic [31:0] s_brk_addr, s_pc;
      s_brk_en = brk_en; s_io_rd = io_rd; s_brk_addr = brk_addr; s_pc = pc;
      clk_run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         brk_en   = vecs[i].brk_en;
         brk_addr = vecs[i].brk_addr;
         pc       = vecs[i].pc;
         io_rd    = vecs[i].io_rd;
         #1;
         chkb($sformatf("table[%0d] cpu_en", i), cpu_en, vecs[i].exp_en);
         chkb($sformatf("table[%0d] pause", i), pause, 1'b0);
      end
      brk_en = s_brk_en; io_rd = s_io_rd; brk_addr = s_brk_addr; pc = s_pc;
      #1;
      clk_run = 1'b1;
   endtask

   task automatic tick();
      @(negedge clk);
      eval_check();
      if (table_req) begin
         table_req = 1'b0;
         run_table();
      end
      @(posedge clk);
      advance();
      ncyc++;
      #1;
      if (en_seen) pc = pc + 32'd4;
      io_rd = io_on && (pc == io_pc);
      if (hold_s > 0) begin hold_s--; if (hold_s == 0) step = 1'b0; end
      if (hold_c > 0) begin hold_c--; if (hold_c == 0) cont = 1'b0; end
      if (hold_e > 0) begin hold_e--; if (hold_e == 0) ent = 1'b0; end
      #1;
   endtask

   task automatic press(input bit s, input bit c, input bit e, input int len);
      if (s) begin step = 1'b1; hold_s = len; due_s = ncyc + LAT; end
      if (c) begin cont = 1'b1; hold_c = len; due_c = ncyc + LAT; end
      if (e) begin ent = 1'b1; hold_e = len; due_e = ncyc + LAT; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_sum, iw_sum, len, sel;
      bit found;
      vecs[0] = '{1'b0, 32'h100, 32'h100, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 32'h100, 32'h100, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h104, 32'h100, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 32'h104, 32'h100, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'h100, 32'h100, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'h000, 32'h100, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 32'h000, 32'hFFFF_FFFC, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0};

      rst = 1'b1; step = 1'b0; cont = 1'b0; ent = 1'b0; brk_en = 1'b0; brk_addr = '0;
      pc = '0; io_rd = 1'b0; io_on = 1'b0; io_pc = '0;
      n_tests = 0; n_fail = 0; ncyc = 0; chk_on = 1'b0; table_req = 1'b0;
      due_s = -1; due_c = -1; due_e = -1; hold_s = 0; hold_c = 0; hold_e = 0;
      m_mode = ModeHalt; m_ret = 0; m_in_vld = 0; m_skip = 0; m_brk_hit = 0; m_cyc = '0;

      // Reset and idle
      tick(); tick();
      rst = 1'b0;
      repeat (20) tick();
      chkb("reset cpu_en", cpu_en, 1'b0);
      chkb("reset pause", pause, 1'b1);
      chkb("reset in_wait", in_wait, 1'b0);
      chkb("reset brk_hit", brk_hit, 1'b0);
      chk("reset cyc_cnt", cyc_cnt, 32'd0);

      // Single step with a long hold yields exactly one instruction
      press(1, 0, 0, 50);
      en_sum = 0;
      repeat (60) begin tick(); en_sum += int'(en_seen); end
      chk("step one cpu_en", 32'(en_sum), 32'd1);
      chk("step cyc_cnt", cyc_cnt, 32'd1);
      chkb("step back to pause", pause, 1'b1);

      // Breakpoint stop and resume
      do_reset();
      pc = '0; brk_en = 1'b1; brk_addr = 32'h10;
      press(0, 1, 0, 8);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (brk_hit) begin found = 1'b1; break; end
      end
      chkb("brk stop seen", found, 1'b1);
      chk("brk pc", pc, 32'h10);
      chkb("brk pause", pause, 1'b1);
      chkb("brk cpu_en", cpu_en, 1'b0);
      chk("brk cyc_cnt", cyc_cnt, 32'd4);
      repeat (10) tick();
      press(0, 1, 0, 8);
      repeat (16) tick();
      chkb("resume running", pause, 1'b0);
      chkb("resume brk_hit clear", brk_hit, 1'b0);
      chkb("resume past brk", pc > 32'h10, 1'b1);
      press(0, 1, 0, 8);
      repeat (16) tick();
      chkb("resume paused again", pause, 1'b1);

      // Input read stall in RUN
      do_reset();
      pc = '0; brk_en = 1'b0; io_on = 1'b1; io_pc = 32'h8; io_rd = 1'b0;
      press(0, 1, 0, 8);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (in_wait) begin found = 1'b1; break; end
      end
      chkb("io wait seen", found, 1'b1);
      chk("io wait pc", pc, 32'h8);
      en_sum = 0; iw_sum = 0;
      repeat (100) begin
         tick();
         en_sum += int'(en_seen);
         iw_sum += int'(in_wait);
      end
      chk("io wait no cpu_en", 32'(en_sum), 32'd0);
      chk("io wait held", 32'(iw_sum), 32'd100);
      chk("io wait cyc_cnt", cyc_cnt, 32'd2);
      press(0, 0, 1, 8);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cpu_en) begin found = 1'b1; break; end
      end
      chkb("io ent releases", found, 1'b1);
      chkb("io read commits with io_rd", io_rd, 1'b1);
      chkb("io in_wait cleared", in_wait, 1'b0);
      tick();
      chk("io pc advanced", pc, 32'hC);
      chkb("io still running", pause, 1'b0);
      table_req = 1'b1;
      tick();
      press(0, 1, 0, 8);
      repeat (16) tick();
      chkb("io paused", pause, 1'b1);

      // Step and cont together: cont wins
      do_reset();
      pc = '0; io_on = 1'b0; io_rd = 1'b0;
      press(1, 1, 0, 8);
      repeat (LAT + 2) tick();
      chkb("both -> run", pause, 1'b0);
      chk("both cyc_cnt", cyc_cnt, 32'd1);
      repeat (8) tick();
      press(0, 1, 0, 8);
      repeat (16) tick();

      // Reset while in IN_WAIT
      do_reset();
      pc = '0; io_on = 1'b1; io_pc = 32'h4;
      press(0, 1, 0, 8);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (in_wait) begin found = 1'b1; break; end
      end
      chkb("rst-wait reached", found, 1'b1);
      repeat (10) tick();
      do_reset();
      chkb("rst-wait pause", pause, 1'b1);
      chkb("rst-wait in_wait", in_wait, 1'b0);
      chk("rst-wait cyc_cnt", cyc_cnt, 32'd0);

      // Cycle counter wrap
      io_on = 1'b0; io_rd = 1'b0;
      force dut.cyc_q = 32'hFFFF_FFFF;
      m_cyc = 32'hFFFF_FFFF;
      tick();
      release dut.cyc_q;
      tick();
      chk("wrap preload", cyc_cnt, 32'hFFFF_FFFF);
      press(1, 0, 0, 8);
      repeat (16) tick();
      chk("wrap to zero", cyc_cnt, 32'd0);
      chkb("wrap paused", pause, 1'b1);

      // Randomized button traffic against the model
      do_reset();
      pc = '0;
      for (int it = 0; it < 60; it++) begin
         brk_en   = 1'($urandom_range(0, 1));
         brk_addr = pc + 32'(4 * $urandom_range(1, 6));
         io_on    = 1'($urandom_range(0, 1));
         io_pc    = pc + 32'(4 * $urandom_range(0, 4));
         io_rd    = io_on && (pc == io_pc);
         sel      = int'($urandom_range(0, 6));
         len      = int'($urandom_range(8, 14));
         case (sel)
            0, 1:    press(1, 0, 0, len);
            2, 3:    press(0, 1, 0, len);
            4:       press(0, 0, 1, len);
            5:       press(1, 1, 0, len);
            default: press(1, 0, 1, len);
         endcase
         repeat (len + int'($urandom_range(8, 20))) tick();
         if ($urandom_range(0, 9) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
